// File: rtl/box_list_loader.sv
// Parses a UDP payload of box records into a pending bank and swaps it into the
// active bank at frame start; stale boxes are aged out after a frame budget.
module box_list_loader #(
    parameter  int BOX_NUM        = 4,
    parameter  int H_ACT          = 1280,
    parameter  int V_ACT          = 720,
    parameter  int C_DEP          = 2,
    parameter  int TIMEOUT_FRAMES = 30,
    localparam int XW             = $clog2(H_ACT),
    localparam int YW             = $clog2(V_ACT)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    input  logic                  rx_last,
    input  logic                  frame_start,
    output logic [BOX_NUM*XW-1:0] start_xs,
    output logic [BOX_NUM*YW-1:0] start_ys,
    output logic [BOX_NUM*XW-1:0] end_xs,
    output logic [BOX_NUM*YW-1:0] end_ys,
    output logic [BOX_NUM*24-1:0] colors,
    output logic [BOX_NUM-1:0]    box_valid,
    output logic                  stale,
    output logic                  pkt_err
);

    localparam int REC_BITS  = 2*XW + 2*YW + 3*C_DEP;
    localparam int REC_BYTES = (REC_BITS + 7) / 8;
    localparam int REC_W     = REC_BYTES * 8;
    localparam int IW        = $clog2(BOX_NUM + 1);
    localparam int BW        = (REC_BYTES > 1) ? $clog2(REC_BYTES) : 1;
    localparam int AW        = (TIMEOUT_FRAMES > 0) ? $clog2(TIMEOUT_FRAMES + 1) : 1;
    localparam int XW1       = XW + 1;
    localparam int YW1       = YW + 1;

    localparam int OFF_SY = REC_W - 1 - XW;
    localparam int OFF_EX = OFF_SY - YW;
    localparam int OFF_EY = OFF_EX - XW;
    localparam int OFF_R  = OFF_EY - YW;
    localparam int OFF_G  = OFF_R - C_DEP;
    localparam int OFF_B  = OFF_G - C_DEP;

    localparam logic [7:0]    N_MAX     = 8'(BOX_NUM);
    localparam logic [BW-1:0] LAST_BYTE = BW'(REC_BYTES - 1);
    localparam logic [AW-1:0] AGE_MAX   = AW'(TIMEOUT_FRAMES);
    localparam logic [XW:0]   H_LIM     = XW1'(H_ACT);
    localparam logic [YW:0]   V_LIM     = YW1'(V_ACT);

    typedef enum logic [2:0] {S_HDR, S_BODY, S_OVER, S_DROP, S_COMMIT} state_t;

    state_t            state_reg, state_next;
    logic [7:0]        n_reg, n_next;
    logic [IW-1:0]     idx_reg, idx_next;
    logic [BW-1:0]     byte_cnt_reg, byte_cnt_next;
    logic [REC_W-1:0]  shift_reg, shift_next;
    logic              pend_flag_reg;
    logic [AW-1:0]     age_reg;
    logic              stale_reg;
    logic              pkt_err_reg, err_next;
    logic              rec_wr, clr_valids, commit;

    logic [XW-1:0]     p_sx [BOX_NUM];
    logic [YW-1:0]     p_sy [BOX_NUM];
    logic [XW-1:0]     p_ex [BOX_NUM];
    logic [YW-1:0]     p_ey [BOX_NUM];
    logic [23:0]       p_col[BOX_NUM];
    logic [BOX_NUM-1:0] p_valid;

    logic [XW-1:0]     a_sx [BOX_NUM];
    logic [YW-1:0]     a_sy [BOX_NUM];
    logic [XW-1:0]     a_ex [BOX_NUM];
    logic [YW-1:0]     a_ey [BOX_NUM];
    logic [23:0]       a_col[BOX_NUM];
    logic [BOX_NUM-1:0] a_valid;

    logic [XW-1:0]     rec_sx, rec_ex;
    logic [YW-1:0]     rec_sy, rec_ey;
    logic [23:0]       rec_col;
    logic              rec_ok;
    logic              last_rec;

    // Replicate a C_DEP-bit channel MSB-first across 8 bits.
    function automatic logic [7:0] expand(input logic [C_DEP-1:0] c);
        logic [7:0] e;
        for (int b = 0; b < 8; b++) begin
            e[7-b] = c[C_DEP-1-(b % C_DEP)];
        end
        return e;
    endfunction

    // Fields are decoded from the post-shift value so the final byte is included.
    assign rec_sx  = shift_next[REC_W-1 -: XW];
    assign rec_sy  = shift_next[OFF_SY -: YW];
    assign rec_ex  = shift_next[OFF_EX -: XW];
    assign rec_ey  = shift_next[OFF_EY -: YW];
    assign rec_col = {expand(shift_next[OFF_R -: C_DEP]),
                      expand(shift_next[OFF_G -: C_DEP]),
                      expand(shift_next[OFF_B -: C_DEP])};
    assign rec_ok  = (rec_sx <= rec_ex) && (rec_sy <= rec_ey) &&
                     ({1'b0, rec_ex} < H_LIM) && ({1'b0, rec_ey} < V_LIM);
    assign last_rec = ((8'(idx_reg) + 8'd1) == n_reg);

    always_comb begin
        state_next    = state_reg;
        n_next        = n_reg;
        idx_next      = idx_reg;
        byte_cnt_next = byte_cnt_reg;
        shift_next    = shift_reg;
        err_next      = 1'b0;
        rec_wr        = 1'b0;
        clr_valids    = 1'b0;
        commit        = 1'b0;
        case (state_reg)
            S_HDR: begin
                if (rx_valid) begin
                    n_next        = rx_data;
                    idx_next      = '0;
                    byte_cnt_next = '0;
                    if (rx_data > N_MAX) begin
                        if (rx_last) err_next   = 1'b1;
                        else         state_next = S_DROP;
                    end else if (rx_data == 8'd0) begin
                        state_next = rx_last ? S_COMMIT : S_OVER;
                    end else if (rx_last) begin
                        err_next = 1'b1;
                    end else begin
                        state_next = S_BODY;
                        clr_valids = 1'b1;
                    end
                end
            end
            S_BODY: begin
                if (rx_valid) begin
                    shift_next = REC_W'({shift_reg, rx_data});
                    if (byte_cnt_reg == LAST_BYTE) begin
                        rec_wr        = 1'b1;
                        byte_cnt_next = '0;
                        idx_next      = idx_reg + IW'(1);
                        if (last_rec) begin
                            state_next = rx_last ? S_COMMIT : S_OVER;
                        end else if (rx_last) begin
                            err_next   = 1'b1;
                            state_next = S_HDR;
                        end
                    end else begin
                        byte_cnt_next = byte_cnt_reg + BW'(1);
                        if (rx_last) begin
                            err_next   = 1'b1;
                            state_next = S_HDR;
                        end
                    end
                end
            end
            S_OVER: begin
                if (rx_valid && rx_last) begin
                    err_next   = 1'b1;
                    state_next = S_COMMIT;
                end
            end
            S_DROP: begin
                if (rx_valid && rx_last) begin
                    err_next   = 1'b1;
                    state_next = S_HDR;
                end
            end
            S_COMMIT: begin
                commit     = 1'b1;
                state_next = S_HDR;
            end
            default: state_next = S_HDR;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg     <= S_HDR;
            n_reg         <= '0;
            idx_reg       <= '0;
            byte_cnt_reg  <= '0;
            shift_reg     <= '0;
            pend_flag_reg <= 1'b0;
            age_reg       <= '0;
            stale_reg     <= 1'b0;
            pkt_err_reg   <= 1'b0;
            p_valid       <= '0;
            a_valid       <= '0;
            for (int i = 0; i < BOX_NUM; i++) begin
                p_sx[i] <= '0; p_sy[i] <= '0; p_ex[i] <= '0; p_ey[i] <= '0; p_col[i] <= '0;
                a_sx[i] <= '0; a_sy[i] <= '0; a_ex[i] <= '0; a_ey[i] <= '0; a_col[i] <= '0;
            end
        end else begin
            state_reg    <= state_next;
            n_reg        <= n_next;
            idx_reg      <= idx_next;
            byte_cnt_reg <= byte_cnt_next;
            shift_reg    <= shift_next;
            pkt_err_reg  <= err_next;

            for (int i = 0; i < BOX_NUM; i++) begin
                if (clr_valids || (commit && (8'(i) >= n_reg))) p_valid[i] <= 1'b0;
            end
            if (rec_wr) begin
                p_sx[idx_reg]    <= rec_sx;
                p_sy[idx_reg]    <= rec_sy;
                p_ex[idx_reg]    <= rec_ex;
                p_ey[idx_reg]    <= rec_ey;
                p_col[idx_reg]   <= rec_col;
                p_valid[idx_reg] <= rec_ok;
            end

            // Swap samples the flag from before this cycle's commit, so a
            // coincident commit lands on the following frame.
            if (commit) begin
                pend_flag_reg <= 1'b1;
            end else if (frame_start && pend_flag_reg) begin
                pend_flag_reg <= 1'b0;
            end

            if (frame_start && pend_flag_reg) begin
                for (int i = 0; i < BOX_NUM; i++) begin
                    a_sx[i] <= p_sx[i]; a_sy[i] <= p_sy[i];
                    a_ex[i] <= p_ex[i]; a_ey[i] <= p_ey[i];
                    a_col[i] <= p_col[i];
                end
                a_valid   <= p_valid;
                age_reg   <= '0;
                stale_reg <= 1'b0;
            end else if (frame_start && (TIMEOUT_FRAMES != 0) && (age_reg != AGE_MAX)) begin
                age_reg <= age_reg + AW'(1);
                if ((age_reg + AW'(1)) == AGE_MAX) begin
                    a_valid   <= '0;
                    stale_reg <= 1'b1;
                end
            end
        end
    end

    generate
        for (genvar gi = 0; gi < BOX_NUM; gi++) begin : g_out
            assign start_xs[gi*XW +: XW] = a_sx[gi];
            assign start_ys[gi*YW +: YW] = a_sy[gi];
            assign end_xs[gi*XW +: XW]   = a_ex[gi];
            assign end_ys[gi*YW +: YW]   = a_ey[gi];
            assign colors[gi*24 +: 24]   = a_col[gi];
        end
    endgenerate

    assign box_valid = a_valid;
    assign stale     = stale_reg;
    assign pkt_err   = pkt_err_reg;

endmodule
